// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for serial_adder
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit-counter width; never below one bit so a register always exists.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/full_adder_dataflow.sv
// rtl/full_adder_dataflow.sv - single-bit combinational full-adder cell
module full_adder_dataflow (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one full-adder cell reused over WIDTH cycles
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             s;
   logic             co;

   full_adder_dataflow u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (c),
      .sum  (s),
      .cout (co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         c     <= 1'b0;
         cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  c     <= cin;
                  cnt   <= '0;
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc  <= {s, acc[WIDTH-1:1]};
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               c    <= co;
               // Counter holds on the final bit so it never wraps inside an operation.
               if (cnt == LAST) begin
                  sum   <= {s, acc[WIDTH-1:1]};
                  cout  <= co;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf   <= (a_sh[0] == b_sh[0]) && (s != a_sh[0]);
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         cin   = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;
   int lat, busy_n, both, extra_done;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,.ovf  (ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called away from the edge; start is sampled at the next rising edge.
   task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      a     = ta;
      b     = tb_v;
      cin   = tc;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // lat counts falling edges after the start edge until done is seen; -1 on timeout.
   task automatic wait_done(output int l, output int bn, output int bd);
      l  = -1;
      bn = 0;
      bd = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) bn++;
         if (busy && done) bd++;
         if (done) begin
            l = i;
            break;
         end
      end
   endtask

   initial begin
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      @(negedge clk) rst_n = 1'b1;

      @(negedge clk);
      launch(8'h3C, 8'h42, 1'b0);
      wait_done(lat, busy_n, both);
      check("t1_lat", lat, W + 1);
      check("t1_busy_cycles", busy_n, W);
      check("t1_busy_done_overlap", both, 0);
      check("t1_sum", sum, 8'h7E);
      check("t1_cout", cout, 0);
      @(negedge clk);
      check("t1_done_pulse", done, 0);
      check("t1_sum_held", sum, 8'h7E);

      launch(8'hFF, 8'h01, 1'b0);
      wait_done(lat, busy_n, both);
      check("t2_sum", sum, 8'h00);
      check("t2_cout", cout, 1);
`ifdef SERIAL_ADDER_OVF_EN
      check("t2_ovf", ovf, 0);
`endif
      @(negedge clk);
      launch(8'h7F, 8'h01, 1'b0);
      wait_done(lat, busy_n, both);
      check("t2b_sum", sum, 8'h80);
      check("t2b_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check("t2b_ovf", ovf, 1);
`endif

      @(negedge clk);
      launch(8'hFF, 8'hFF, 1'b1);
      repeat (3) @(negedge clk);
      a     = 8'h12;
      b     = 8'h34;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(lat, busy_n, both);
      check("t3_sum", sum, 8'hFF);
      check("t3_cout", cout, 1);
`ifdef SERIAL_ADDER_OVF_EN
      check("t3_ovf", ovf, 0);
`endif

      // Still in the done cycle: restart back-to-back.
      launch(8'h10, 8'h01, 1'b0);
      wait_done(lat, busy_n, both);
      check("t4_lat", lat, W + 1);
      check("t4_busy_cycles", busy_n, W);
      check("t4_overlap", both, 0);
      check("t4_sum", sum, 8'h11);

      @(negedge clk);
      launch(8'hAA, 8'h55, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      check("t5_busy_before_rst", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_sum", sum, 0);
      check("t5_rst_cout", cout, 0);
      @(negedge clk) rst_n = 1'b1;
      extra_done = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) extra_done++;
      end
      check("t5_no_done_after_rst", extra_done, 0);
      launch(8'h05, 8'h03, 1'b0);
      wait_done(lat, busy_n, both);
      check("t5_lat", lat, W + 1);
      check("t5_sum", sum, 8'h08);
      check("t5_cout", cout, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
